// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: two-source AXI4-Stream video arbiter that forwards whole
// frames only, with round-robin choice on simultaneous SOF and a single
// registered output stage.
// Optional: define AXIS_FRAME_ARBITER_CHECK_EN to add the sticky frame_err
// output that flags malformed line/frame structure from the owning source.
module axis_frame_arbiter #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64
) (
   input  logic        s_axis_video_aclk,
   input  logic        rst,
   input  logic [23:0] VIDEO_IN0_tdata,
   input  logic        VIDEO_IN0_tuser,
   input  logic        VIDEO_IN0_tlast,
   input  logic        VIDEO_IN0_tvalid,
   output logic        VIDEO_IN0_tready,
   input  logic [23:0] VIDEO_IN1_tdata,
   input  logic        VIDEO_IN1_tuser,
   input  logic        VIDEO_IN1_tlast,
   input  logic        VIDEO_IN1_tvalid,
   output logic        VIDEO_IN1_tready,
   output logic [23:0] VIDEO_OUT_tdata,
   output logic        VIDEO_OUT_tuser,
   output logic        VIDEO_OUT_tlast,
   output logic        VIDEO_OUT_tvalid,
   input  logic        VIDEO_OUT_tready,
   output logic [1:0]  grant
`ifdef AXIS_FRAME_ARBITER_CHECK_EN
   ,
   output logic        frame_err
`endif
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t        state;
   logic          pref1;      // 1: source 1 wins the next simultaneous SOF
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   logic          out_free;
   logic          sof0, sof1, win0, win1;
   logic          fwd, sel1;
   logic [23:0]   in_data;
   logic          in_user, in_last;
   logic [CW-1:0] col_e;
   logic [RW-1:0] row_e;
   logic          eof;

   // Handshake steering: the output slot is free when empty or draining this
   // cycle. In IDLE a losing SOF is held off (tready low) so its frame is not
   // lost; IDLE also waits on a free slot so a stalled EOL beat is never
   // overwritten by the next SOF.
   always_comb begin
      out_free         = !VIDEO_OUT_tvalid | VIDEO_OUT_tready;
      sof0             = VIDEO_IN0_tvalid & VIDEO_IN0_tuser;
      sof1             = VIDEO_IN1_tvalid & VIDEO_IN1_tuser;
      win0             = sof0 & (!sof1 | !pref1);
      win1             = sof1 & (!sof0 | pref1);
      VIDEO_IN0_tready = 1'b0;
      VIDEO_IN1_tready = 1'b0;
      fwd              = 1'b0;
      sel1             = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               VIDEO_IN0_tready = out_free & !win1;
               VIDEO_IN1_tready = out_free & !win0;
               sel1             = win1;
               fwd              = out_free & (win0 | win1);
            end
            OWN0: begin
               VIDEO_IN0_tready = out_free;
               fwd              = VIDEO_IN0_tvalid & out_free;
            end
            OWN1: begin
               VIDEO_IN1_tready = out_free;
               sel1             = 1'b1;
               fwd              = VIDEO_IN1_tvalid & out_free;
            end
            default: ;
         endcase
      end
      in_data = sel1 ? VIDEO_IN1_tdata : VIDEO_IN0_tdata;
      in_user = sel1 ? VIDEO_IN1_tuser : VIDEO_IN0_tuser;
      in_last = sel1 ? VIDEO_IN1_tlast : VIDEO_IN0_tlast;
      // An SOF beat is pixel (0,0) regardless of where the counters stood.
      col_e   = in_user ? '0 : col;
      row_e   = in_user ? '0 : row;
      eof     = in_last & (row_e == ROW_LAST);
   end

   // Ownership FSM, position counters, round-robin pointer and output register.
   always_ff @(posedge s_axis_video_aclk) begin
      if (rst) begin
         state            <= IDLE;
         pref1            <= 1'b0;
         col              <= '0;
         row              <= '0;
         grant            <= 2'b00;
         VIDEO_OUT_tdata  <= '0;
         VIDEO_OUT_tuser  <= 1'b0;
         VIDEO_OUT_tlast  <= 1'b0;
         VIDEO_OUT_tvalid <= 1'b0;
      end else begin
         if (fwd) begin
            VIDEO_OUT_tdata  <= in_data;
            VIDEO_OUT_tuser  <= in_user;
            VIDEO_OUT_tlast  <= in_last;
            VIDEO_OUT_tvalid <= 1'b1;
         end else if (VIDEO_OUT_tready) begin
            VIDEO_OUT_tvalid <= 1'b0;
         end

         if (fwd) begin
            if (in_last) begin
               col <= '0;
               row <= (row_e == ROW_LAST) ? '0 : row_e + 1'b1;
            end else begin
               col <= (col_e == COL_LAST) ? '0 : col_e + 1'b1;
               row <= row_e;
            end

            if (eof) begin
               state <= IDLE;
               grant <= 2'b00;
            end else if (state == IDLE) begin
               state <= sel1 ? OWN1 : OWN0;
               grant <= sel1 ? 2'b10 : 2'b01;
            end

            if (state == IDLE) begin
               pref1 <= !sel1;
            end
         end
      end
   end

`ifdef AXIS_FRAME_ARBITER_CHECK_EN
   // Sticky structure check on every forwarded beat of the owning source.
   always_ff @(posedge s_axis_video_aclk) begin
      if (rst) begin
         frame_err <= 1'b0;
      end else if (fwd) begin
         if ((in_last && (col_e != COL_LAST)) ||
             (!in_last && (col_e == COL_LAST)) ||
             (in_user && (state != IDLE) && ((col != '0) || (row != '0)))) begin
            frame_err <= 1'b1;
         end
      end
   end
`endif

endmodule
